// File: rtl/hazard_tag_pipe.sv
// Hazard detection and EX/MEM/WB address-tag pipeline feeding forwarding control; optional stall counter under HAZARD_STAT_EN.
// Latency: tags advance one stage per non-frozen edge; Stall is combinational from current stage state and ID inputs.
// Backpressure: Stall bubbles EX while MEM/WB advance; Freeze holds every register; reset overrides both.
module hazard_tag_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1_ID,
    input  logic [4:0]  A2_ID,
    input  logic [4:0]  A3_ID,
    input  logic [1:0]  Tnew_ID,
    input  logic [1:0]  Use1_ID,
    input  logic [1:0]  Use2_ID,
    input  logic        Freeze,
    output logic        Stall,
    output logic [4:0]  A1_EX,
    output logic [4:0]  A2_EX,
    output logic [4:0]  A2_MEM,
    output logic [4:0]  A3_EX,
    output logic [4:0]  A3_MEM,
    output logic [4:0]  A3_WB,
    output logic [1:0]  Tnew_EX,
    output logic [1:0]  Tnew_MEM,
    output logic [1:0]  Tnew_WB
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0] StallCnt
`endif
);

    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_NONE = 2'd3;

    localparam logic [1:0] USE_ID    = 2'd0;
    localparam logic [1:0] USE_EX    = 2'd1;
    localparam logic [1:0] USE_NONE  = 2'd3;

    logic       haz1;
    logic       haz2;
    logic [4:0] cap_a1;
    logic [4:0] cap_a2;
    logic [4:0] cap_a3;
    logic [1:0] cap_tnew;

    // A producer in EX is still computing (ALU) or fetching (load); in MEM only a load is unresolved.
    function automatic logic src_hazard(
        input logic [4:0] a,
        input logic [1:0] u,
        input logic [4:0] a3_ex,
        input logic [1:0] tnew_ex,
        input logic [4:0] a3_mem,
        input logic [1:0] tnew_mem
    );
        logic h;
        h = 1'b0;
        if (a != 5'd0 && u != USE_NONE) begin
            if (u == USE_ID) begin
                h = (a == a3_ex  && (tnew_ex == TNEW_ALU || tnew_ex == TNEW_LOAD)) ||
                    (a == a3_mem && tnew_mem == TNEW_LOAD);
            end else if (u == USE_EX) begin
                h = (a == a3_ex && tnew_ex == TNEW_LOAD);
            end
        end
        return h;
    endfunction

    always_comb begin
        haz1  = src_hazard(A1_ID, Use1_ID, A3_EX, Tnew_EX, A3_MEM, Tnew_MEM);
        haz2  = src_hazard(A2_ID, Use2_ID, A3_EX, Tnew_EX, A3_MEM, Tnew_MEM);
        Stall = haz1 | haz2;
    end

    // Normalise captured tags so unused sources and non-writing producers never match.
    always_comb begin
        cap_a1   = (Use1_ID == USE_NONE) ? 5'd0 : A1_ID;
        cap_a2   = (Use2_ID == USE_NONE) ? 5'd0 : A2_ID;
        cap_a3   = A3_ID;
        cap_tnew = Tnew_ID;
        if (A3_ID == 5'd0 || Tnew_ID == TNEW_NONE) begin
            cap_a3   = 5'd0;
            cap_tnew = TNEW_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            A1_EX    <= 5'd0;
            A2_EX    <= 5'd0;
            A3_EX    <= 5'd0;
            Tnew_EX  <= TNEW_NONE;
            A2_MEM   <= 5'd0;
            A3_MEM   <= 5'd0;
            Tnew_MEM <= TNEW_NONE;
            A3_WB    <= 5'd0;
            Tnew_WB  <= TNEW_NONE;
        end else if (!Freeze) begin
            A3_WB    <= A3_MEM;
            Tnew_WB  <= Tnew_MEM;
            A2_MEM   <= A2_EX;
            A3_MEM   <= A3_EX;
            Tnew_MEM <= Tnew_EX;
            if (Stall) begin
                A1_EX   <= 5'd0;
                A2_EX   <= 5'd0;
                A3_EX   <= 5'd0;
                Tnew_EX <= TNEW_NONE;
            end else begin
                A1_EX   <= cap_a1;
                A2_EX   <= cap_a2;
                A3_EX   <= cap_a3;
                Tnew_EX <= cap_tnew;
            end
        end
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= 32'd0;
        end else if (Stall && !Freeze) begin
            StallCnt <= StallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Self-checking bench for hazard_tag_pipe: directed hazard scenarios plus randomized traffic against a readiness-based model.
module tb_hazard_tag_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] A1_ID, A2_ID, A3_ID;
    logic [1:0] Tnew_ID, Use1_ID, Use2_ID;
    logic       Freeze;
    logic       Stall;
    logic [4:0] A1_EX, A2_EX, A2_MEM, A3_EX, A3_MEM, A3_WB;
    logic [1:0] Tnew_EX, Tnew_MEM, Tnew_WB;
`ifdef HAZARD_STAT_EN
    logic [31:0] StallCnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_tag_pipe dut (
        .clk(clk), .reset(reset),
        .A1_ID(A1_ID), .A2_ID(A2_ID), .A3_ID(A3_ID),
        .Tnew_ID(Tnew_ID), .Use1_ID(Use1_ID), .Use2_ID(Use2_ID),
        .Freeze(Freeze), .Stall(Stall),
        .A1_EX(A1_EX), .A2_EX(A2_EX), .A2_MEM(A2_MEM),
        .A3_EX(A3_EX), .A3_MEM(A3_MEM), .A3_WB(A3_WB),
        .Tnew_EX(Tnew_EX), .Tnew_MEM(Tnew_MEM), .Tnew_WB(Tnew_WB)
`ifdef HAZARD_STAT_EN
        , .StallCnt(StallCnt)
`endif
    );

    // Reference model: an in-flight instruction list (EX, MEM, WB) plus a readiness rule.
    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic [1:0] tnew;
    } instr_t;

    localparam instr_t BUB = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, tnew: 2'd3};

    instr_t      m [3] = '{BUB, BUB, BUB};
    logic [31:0] mcnt = 32'd0;

    // Pipeline position of ID=1, EX=2, MEM=3, WB=4; a value is forwardable once its producer reaches this position.
    function automatic int ready_pos(input logic [1:0] t);
        case (t)
            2'd0:    return 2;
            2'd1:    return 3;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    // A consumer needing the value u cycles from now stalls if the producer cannot reach readiness by then.
    function automatic logic model_haz(input logic [4:0] a, input logic [1:0] u);
        if (a == 0 || u == 3) return 1'b0;
        for (int p = 2; p <= 4; p++) begin
            if (m[p-2].tnew != 3 && m[p-2].a3 == a && (p + int'(u)) < ready_pos(m[p-2].tnew))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        return model_haz(A1_ID, Use1_ID) | model_haz(A2_ID, Use2_ID);
    endfunction

    function automatic instr_t model_capture();
        instr_t c;
        c.a1   = (Use1_ID == 3) ? 5'd0 : A1_ID;
        c.a2   = (Use2_ID == 3) ? 5'd0 : A2_ID;
        c.a3   = (A3_ID == 0 || Tnew_ID == 3) ? 5'd0 : A3_ID;
        c.tnew = (A3_ID == 0 || Tnew_ID == 3) ? 2'd3 : Tnew_ID;
        return c;
    endfunction

    function automatic logic [35:0] exp_tags();
        return {m[0].a1, m[0].a2, m[1].a2, m[0].a3, m[1].a3, m[2].a3, m[0].tnew, m[1].tnew, m[2].tnew};
    endfunction

    function automatic logic [35:0] got_tags();
        return {A1_EX, A2_EX, A2_MEM, A3_EX, A3_MEM, A3_WB, Tnew_EX, Tnew_MEM, Tnew_WB};
    endfunction

    task automatic tick();
        logic s;
        s = model_stall();
        @(posedge clk);
        if (reset) begin
            m    = '{BUB, BUB, BUB};
            mcnt = 32'd0;
        end else if (!Freeze) begin
            if (s) mcnt = mcnt + 32'd1;
            m[2] = m[1];
            m[1] = m[0];
            m[0] = s ? BUB : model_capture();
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] a1, input logic [1:0] u1,
                         input logic [4:0] a2, input logic [1:0] u2,
                         input logic [4:0] a3, input logic [1:0] tn);
        A1_ID = a1; Use1_ID = u1; A2_ID = a2; Use2_ID = u2; A3_ID = a3; Tnew_ID = tn;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    endtask

    task automatic do_reset();
        nop();
        Freeze = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(5'd7, 2'd1, 5'd9, 2'd0, 5'd7, 2'd2);
        Freeze = 1'b1;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        Freeze = 1'b0;
        nop();
        @(negedge clk);
        total++;
        if (got_tags() !== {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd3}) begin
            bad++; $display("FAIL reset_tags got=%h exp=%h", got_tags(), {30'd0, 6'h3f});
        end
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", Stall); end
`ifdef HAZARD_STAT_EN
        total++;
        if (StallCnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", StallCnt); end
`endif
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);       // lw $8
        tick();
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd12, 2'd1);      // add $12, $8
        @(negedge clk);
        total++;
        if (Stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b exp=1", Stall); end
        tick();
        @(negedge clk);
        total++;
        if ({A3_EX, Tnew_EX, A3_MEM, Tnew_MEM} !== {5'd0, 2'd3, 5'd8, 2'd2}) begin
            bad++; $display("FAIL load_use_bubble got=%h exp=%h", {A3_EX, Tnew_EX, A3_MEM, Tnew_MEM}, {5'd0, 2'd3, 5'd8, 2'd2});
        end
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL load_use_release got=%b exp=0", Stall); end
        tick();
        nop();
        total++;
        if ({A1_EX, A3_EX, Tnew_EX} !== {5'd8, 5'd12, 2'd1}) begin
            bad++; $display("FAIL load_use_capture got=%h exp=%h", {A1_EX, A3_EX, Tnew_EX}, {5'd8, 5'd12, 2'd1});
        end
`ifdef HAZARD_STAT_EN
        total++;
        if (StallCnt !== 32'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=1", StallCnt); end
`endif
    endtask

    task automatic test_branch_alu();
        do_reset();
        drive(5'd1, 2'd1, 5'd2, 2'd1, 5'd9, 2'd1);       // add $9
        tick();
        drive(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);       // beq $9
        @(negedge clk);
        total++;
        if (Stall !== 1'b1) begin bad++; $display("FAIL br_alu_stall got=%b exp=1", Stall); end
        tick();
        @(negedge clk);
        total++;
        if ({Stall, A3_MEM} !== {1'b0, 5'd9}) begin
            bad++; $display("FAIL br_alu_release got=%h exp=%h", {Stall, A3_MEM}, {1'b0, 5'd9});
        end
        tick();
    endtask

    task automatic test_branch_load();
        int n;
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd2);      // lw $10
        tick();
        drive(5'd0, 2'd3, 5'd10, 2'd0, 5'd0, 2'd3);      // beq on source 2
        n = 0;
        @(negedge clk);
        while (Stall === 1'b1 && n < 6) begin
            tick();
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL br_load_cycles got=%0d exp=2", n); end
        tick();
    endtask

    task automatic test_store();
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 2'd2);      // lw $11
        tick();
        drive(5'd5, 2'd1, 5'd11, 2'd2, 5'd0, 2'd3);      // sw $11, 0($5)
        @(negedge clk);
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%b exp=0", Stall); end
        tick();
        nop();
        tick();
        total++;
        if ({A2_MEM, A3_WB, Tnew_WB} !== {5'd11, 5'd11, 2'd2}) begin
            bad++; $display("FAIL store_tags got=%h exp=%h", {A2_MEM, A3_WB, Tnew_WB}, {5'd11, 5'd11, 2'd2});
        end
    endtask

    task automatic test_freeze();
        logic [35:0] snap;
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);
        tick();
        drive(5'd8, 2'd1, 5'd8, 2'd1, 5'd13, 2'd1);
        @(negedge clk);
        snap = got_tags();
        Freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            total++;
            if ({Stall, got_tags()} !== {1'b1, snap}) begin
                bad++; $display("FAIL freeze_hold%0d got=%h exp=%h", i, {Stall, got_tags()}, {1'b1, snap});
            end
        end
`ifdef HAZARD_STAT_EN
        total++;
        if (StallCnt !== 32'd0) begin bad++; $display("FAIL freeze_cnt_hold got=%0d exp=0", StallCnt); end
`endif
        Freeze = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if ({Stall, A3_EX, Tnew_EX, A3_MEM} !== {1'b0, 5'd0, 2'd3, 5'd8}) begin
            bad++; $display("FAIL freeze_release got=%h exp=%h", {Stall, A3_EX, Tnew_EX, A3_MEM}, {1'b0, 5'd0, 2'd3, 5'd8});
        end
`ifdef HAZARD_STAT_EN
        total++;
        if (StallCnt !== 32'd1) begin bad++; $display("FAIL freeze_cnt_inc got=%0d exp=1", StallCnt); end
`endif
        tick();
    endtask

    task automatic test_zero();
        do_reset();
        drive(5'd3, 2'd1, 5'd4, 2'd3, 5'd0, 2'd1);       // writes $0, source 2 unused
        tick();
        total++;
        if ({A1_EX, A2_EX, A3_EX, Tnew_EX} !== {5'd3, 5'd0, 5'd0, 2'd3}) begin
            bad++; $display("FAIL zero_dest got=%h exp=%h", {A1_EX, A2_EX, A3_EX, Tnew_EX}, {5'd3, 5'd0, 5'd0, 2'd3});
        end
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd3);       // no-write class clears A3
        tick();
        total++;
        if ({A3_EX, Tnew_EX} !== {5'd0, 2'd3}) begin
            bad++; $display("FAIL nowrite_dest got=%h exp=%h", {A3_EX, Tnew_EX}, {5'd0, 2'd3});
        end
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd14, 2'd2);      // lw $14
        tick();
        drive(5'd0, 2'd0, 5'd14, 2'd3, 5'd0, 2'd3);      // reads $0 at ID, $14 marked unused
        @(negedge clk);
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL zero_read_stall got=%b exp=0", Stall); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);
        tick();
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd12, 2'd1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd15, 2'd2);      // lw $15
        tick();
        drive(5'd15, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);      // beq $15 stalls
        @(negedge clk);
        total++;
        if (Stall !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", Stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({Stall, got_tags()} !== {1'b0, 30'd0, 6'h3f}) begin
            bad++; $display("FAIL rst_mid_post got=%h exp=%h", {Stall, got_tags()}, {1'b0, 30'd0, 6'h3f});
        end
`ifdef HAZARD_STAT_EN
        total++;
        if (StallCnt !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", StallCnt); end
`endif
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            Freeze = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            total++;
            if (Stall !== model_stall()) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_stall cyc=%0d got=%b exp=%b", i, Stall, model_stall());
            end
            total++;
            if (got_tags() !== exp_tags()) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_tags cyc=%0d got=%h exp=%h", i, got_tags(), exp_tags());
            end
`ifdef HAZARD_STAT_EN
            total++;
            if (StallCnt !== mcnt) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, StallCnt, mcnt);
            end
`endif
            tick();
        end
        reset  = 1'b0;
        Freeze = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        Freeze = 1'b0;
        nop();
        test_reset();
        test_load_use();
        test_branch_alu();
        test_branch_load();
        test_store();
        test_freeze();
        test_zero();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
